// File: rtl/dfm_pkg.sv
// dfm_pkg: shared state encoding, measurement word field positions and error bit indices
package dfm_pkg;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
  localparam int REF_CNT_MSB = 63;
  localparam int REF_CNT_LSB = 32;
  localparam int SIG_CNT_MSB = 31;
  localparam int SIG_CNT_LSB = 0;
  localparam int ERR_DIV0 = 0;
  localparam int ERR_OVF = 1;
endpackage

// File: rtl/seq_div_u64.sv
// seq_div_u64: 64/32 restoring divider, one quotient bit per cycle, fixed 64-cycle run
module seq_div_u64 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [63:0] dvd_i,
  input  logic [31:0] den_i,
  output logic        done_o,
  output logic [63:0] quot_o
);
  logic        run_q, run_d, ge;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, den_q, den_d;
  logic [32:0] sh;
  logic [63:0] dvd_q, dvd_d;
  always_comb begin
    sh = {rem_q, dvd_q[63]};
    ge = sh >= {1'b0, den_q};
    done_o = run_q && cnt_q == '0;
    run_d = start_i ? 1'b1 : done_o ? 1'b0 : run_q;
    cnt_d = start_i ? 6'd63 : run_q ? cnt_q - 6'd1 : cnt_q;
    rem_d = start_i ? '0 : run_q ? (ge ? 32'(sh - {1'b0, den_q}) : sh[31:0]) : rem_q;
    dvd_d = start_i ? dvd_i : run_q ? {dvd_q[62:0], ge} : dvd_q;
    den_d = start_i ? den_i : den_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      dvd_q <= '0;
      den_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      dvd_q <= dvd_d;
      den_q <= den_d;
    end
  end
  assign quot_o = dvd_q;
endmodule

// File: rtl/freq_calc.sv
// freq_calc: frequency = sig_cnt * REF_CLK_HZ / ref_cnt with saturation, div-by-zero flag and drop detection
module freq_calc
  import dfm_pkg::*;
#(
  parameter logic [31:0] REF_CLK_HZ = 32'd100_000_000,
  parameter int          CNT_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               meas_vld_i,
  input  logic [2*CNT_W-1:0] meas_data_i,
  output logic               busy_o,
  output logic               drop_o,
  output logic               res_vld_o,
  output logic [CNT_W-1:0]   res_freq_o,
  output logic [1:0]         res_err_o
);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   ref_q, ref_d, sig_q, sig_d, freq_q, freq_d, freq_sel;
  logic [1:0]         err_q, err_d, err_sel;
  logic [63:0]        quot;
  logic               div_done, take;
  seq_div_u64 u_div (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(state_q == MUL),
    .dvd_i  (64'(sig_q) * 64'(REF_CLK_HZ)),
    .den_i  (ref_q),
    .done_o (div_done),
    .quot_o (quot)
  );
  always_comb begin
    take = state_q == IDLE && meas_vld_i;
    state_d = state_q == IDLE ? (meas_vld_i ? MUL : IDLE) :
              state_q == MUL  ? DIV :
              state_q == DIV  ? (div_done ? DONE : DIV) : IDLE;
    ref_d = take ? meas_data_i[REF_CNT_MSB:REF_CNT_LSB] : ref_q;
    sig_d = take ? meas_data_i[SIG_CNT_MSB:SIG_CNT_LSB] : sig_q;
    err_sel = '0;
    err_sel[ERR_DIV0] = ref_q == '0;
    err_sel[ERR_OVF] = ref_q != '0 && quot[63:CNT_W] != '0;
    freq_sel = |err_sel ? '1 : quot[CNT_W-1:0];
    freq_d = state_q == DONE ? freq_sel : freq_q;
    err_d = state_q == DONE ? err_sel : err_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ref_q   <= '0;
      sig_q   <= '0;
      freq_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      sig_q   <= sig_d;
      freq_q  <= freq_d;
      err_q   <= err_d;
    end
  end
  // Result is visible during DONE itself; the registers take it over for the hold period
  assign busy_o     = state_q != IDLE;
  assign drop_o     = meas_vld_i && busy_o && !rst_i;
  assign res_vld_o  = state_q == DONE;
  assign res_freq_o = res_vld_o ? freq_sel : freq_q;
  assign res_err_o  = res_vld_o ? err_sel : err_q;
endmodule

// File: tb/tb_freq_calc.sv
// tb_freq_calc: directed checks of latency, arithmetic, saturation, drop and abort behaviour
module tb_freq_calc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        meas_vld = 1'b0;
  logic [63:0] meas_data = '0;
  logic        busy, drop, res_vld;
  logic [31:0] res_freq;
  logic [1:0]  res_err;
  int          checks = 0;
  int          fails = 0;

  freq_calc dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .meas_vld_i (meas_vld),
    .meas_data_i(meas_data),
    .busy_o     (busy),
    .drop_o     (drop),
    .res_vld_o  (res_vld),
    .res_freq_o (res_freq),
    .res_err_o  (res_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] r, input logic [31:0] s);
    meas_vld = 1'b1;
    meas_data = {r, s};
    @(negedge clk);
    meas_vld = 1'b0;
  endtask

  task automatic wait_res(output int n);
    n = 1;
    while (!res_vld && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic compute(input string tag, input logic [31:0] r, input logic [31:0] s,
                         input logic [31:0] ef, input logic [1:0] ee);
    int n;
    send(r, s);
    chk({tag, "_busy"}, busy, 1);
    wait_res(n);
    chk({tag, "_lat"}, n, 66);
    chk({tag, "_freq"}, res_freq, ef);
    chk({tag, "_err"}, res_err, ee);
    @(negedge clk);
    chk({tag, "_vld_pulse"}, res_vld, 0);
    chk({tag, "_hold"}, {res_err, res_freq}, {ee, ef});
  endtask

  initial begin
    int n, seen;
    repeat (2) @(negedge clk);
    meas_vld = 1'b1;
    meas_data = {32'd3, 32'd10};
    #1;
    chk("rst_drop", drop, 0);
    chk("rst_outs", {busy, res_vld, res_err, res_freq}, 0);
    @(negedge clk);
    rst = 1'b0;
    meas_vld = 1'b0;
    chk("rst_ignored_vld", busy, 0);

    compute("f1000", 32'd100_000_000, 32'd1000, 32'd1000, 2'b00);
    compute("div3", 32'd3, 32'd10, 32'd333_333_333, 2'b00);
    compute("div7", 32'd7, 32'd1, 32'd14_285_714, 2'b00);
    compute("div0", 32'd0, 32'd5, 32'hFFFF_FFFF, 2'b01);
    compute("ovf", 32'd1, 32'd100, 32'hFFFF_FFFF, 2'b10);
    compute("sig0", 32'd50, 32'd0, 32'd0, 2'b00);
    compute("max_fit", 32'd100_000_000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00);
    compute("just_ovf", 32'd99_999_999, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10);

    // second word 10 cycles in, third coincident with res_vld
    send(32'd3, 32'd10);
    n = 1;
    seen = 0;
    while (n < 66) begin
      if (n == 10) begin
        meas_vld = 1'b1;
        meas_data = {32'd1, 32'd1};
        #1;
        chk("drop_mid", drop, 1);
      end
      if (res_vld) seen++;
      @(negedge clk);
      meas_vld = 1'b0;
      n++;
    end
    chk("drop_early_vld", seen, 0);
    chk("drop_vld", res_vld, 1);
    meas_vld = 1'b1;
    meas_data = {32'd1, 32'd2};
    #1;
    chk("drop_done", drop, 1);
    chk("drop_freq", res_freq, 32'd333_333_333);
    chk("drop_err", res_err, 2'b00);
    @(negedge clk);
    meas_vld = 1'b0;
    #1;
    chk("drop_clear", drop, 0);
    seen = 0;
    repeat (80) begin
      if (res_vld || busy) seen++;
      @(negedge clk);
    end
    chk("drop_single_res", seen, 0);

    // abort 30 cycles into DIV
    send(32'd7, 32'd1);
    repeat (31) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_outs", {res_vld, res_err, res_freq}, 0);
    seen = 0;
    repeat (80) begin
      if (res_vld) seen++;
      @(negedge clk);
    end
    chk("abort_no_res", seen, 0);
    compute("after_abort", 32'd100_000_000, 32'd1000, 32'd1000, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
